// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Frame format (5-8 data bits, optional parity, 1 or 2 stop bits) is latched per frame.
module uart_tx_fifo #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    output logic                         tx_o,
    output logic                         busy_o,
    input  logic                         cfg_en_i,
    input  logic [DIV_WIDTH-1:0]         cfg_div_i,
    input  logic                         cfg_parity_en_i,
    input  logic [1:0]                   cfg_parity_sel_i,
    input  logic [1:0]                   cfg_bits_i,
    input  logic                         cfg_stop_bits_i,
    input  logic                         cfg_break_i,
    input  logic                         fifo_clr_i,
    input  logic [7:0]                   tx_data_i,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_o,
    output logic                         fifo_empty_o,
    output logic                         fifo_full_o,
    output logic                         tx_done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    rd_data;
    logic          push, pop;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d;
    logic [7:0]           shr_q, shr_d;
    logic [2:0]           bitn_q, bitn_d;
    logic [1:0]           bits_q, bits_d;
    logic                 par_en_q, par_en_d;
    logic [1:0]           par_sel_q, par_sel_d;
    logic                 stop2_q, stop2_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic       bit_end, start_ok, launch;
    logic [2:0] last_idx;
    logic [7:0] data_m;

    assign fifo_cnt_o   = cnt_q;
    assign fifo_empty_o = (cnt_q == '0);
    assign fifo_full_o  = (cnt_q == FULL_CNT);
    assign tx_ready_o   = cfg_en_i & ~fifo_full_o & ~fifo_clr_i;
    assign push         = tx_valid_i & tx_ready_o;
    assign rd_data      = mem_q[rd_ptr_q];

    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign tx_done_o = done_q;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (fifo_clr_i) begin
            cnt_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (fifo_clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ---------------- transmitter FSM ----------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        shr_d     = shr_q;
        bitn_d    = bitn_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        par_sel_d = par_sel_q;
        stop2_d   = stop2_q;
        par_d     = par_q;
        pop       = 1'b0;
        launch    = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        bit_end   = (baud_q >= cfg_div_i);
        start_ok  = cfg_en_i & ~fifo_empty_o & ~cfg_break_i & ~fifo_clr_i;
        last_idx  = 3'd4 + {1'b0, bits_q};
        data_m    = rd_data & (8'hFF >> (2'd3 - cfg_bits_i));

        if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;

        // IDLE and the end of the final stop bit share the launch path, so
        // consecutive frames chain with no idle cycle between them.
        case (state_q)
            IDLE:   launch = 1'b1;
            START:  if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shr_d  = shr_q >> 1;
                    bitn_d = bitn_q + 1'b1;
                    if (bitn_q == last_idx) begin
                        bitn_d  = '0;
                        state_d = par_en_q ? PARITY : STOP1;
                    end
                end
            end
            PARITY: if (bit_end) state_d = STOP1;
            STOP1: begin
                if (bit_end) begin
                    if (stop2_q) state_d = STOP2;
                    else         launch  = 1'b1;
                end
            end
            STOP2:   if (bit_end) launch = 1'b1;
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = IDLE;
            if (start_ok) begin
                pop       = 1'b1;
                state_d   = START;
                baud_d    = '0;
                shr_d     = data_m;
                bitn_d    = '0;
                bits_d    = cfg_bits_i;
                par_en_d  = cfg_parity_en_i;
                par_sel_d = cfg_parity_sel_i;
                stop2_d   = cfg_stop_bits_i;
                par_d     = ^data_m;
            end
        end

        if (!cfg_en_i) begin
            state_d = IDLE;
            baud_d  = '0;
        end

        // Outputs are registered: derive them from the next state.
        case (state_d)
            IDLE:  tx_d = ~(cfg_en_i & cfg_break_i);
            START: tx_d = 1'b0;
            DATA:  tx_d = shr_d[0];
            PARITY: begin
                case (par_sel_d)
                    2'b00:   tx_d = ~par_d;
                    2'b01:   tx_d = par_d;
                    2'b10:   tx_d = 1'b0;
                    default: tx_d = 1'b1;
                endcase
            end
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = ((state_d == STOP1 && !stop2_d) || state_d == STOP2) &&
                 (baud_d >= cfg_div_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            shr_q     <= '0;
            bitn_q    <= '0;
            bits_q    <= '0;
            par_en_q  <= 1'b0;
            par_sel_q <= '0;
            stop2_q   <= 1'b0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shr_q     <= shr_d;
            bitn_q    <= bitn_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            par_sel_q <= par_sel_d;
            stop2_q   <= stop2_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-level line monitor checks every cycle of every
// frame against the byte expected from a queue model of the FIFO.
module tb_uart_tx_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx, busy, ready, empty, full, done;
    logic [3:0]    cnt;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic          par_en = 1'b0;
    logic [1:0]    par_sel = 2'b00;
    logic [1:0]    bits = 2'b11;
    logic          stop2 = 1'b0;
    logic          brk = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;

    int         nchk = 0, nerr = 0;
    logic [7:0] exp_q[$];
    logic       mon_on = 1'b0, bcnt_clr = 1'b0, full_seen = 1'b0;
    int         busy_cyc = 0, nfr = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DIV_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .tx_o(tx), .busy_o(busy),
        .cfg_en_i(cfg_en), .cfg_div_i(cfg_div), .cfg_parity_en_i(par_en),
        .cfg_parity_sel_i(par_sel), .cfg_bits_i(bits), .cfg_stop_bits_i(stop2),
        .cfg_break_i(brk), .fifo_clr_i(clr), .tx_data_i(tx_data),
        .tx_valid_i(tx_valid), .tx_ready_o(ready), .fifo_cnt_o(cnt),
        .fifo_empty_o(empty), .fifo_full_o(full), .tx_done_o(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_rdy();
        return cfg_en && (exp_q.size() < DEPTH) && !clr;
    endfunction

    always @(posedge clk) busy_cyc <= bcnt_clr ? 0 : busy_cyc + (busy ? 1 : 0);

    // Line monitor: on a start bit, build the whole expected bit sequence from
    // the frame format and check the line and tx_done every cycle.
    task automatic rx_frame();
        logic [7:0]  d, obs;
        logic [11:0] ev;
        int n, p, l, bad, dbad;
        obs = '0; ev = '0; bad = 0; dbad = 0;
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            d = '0;
        end else begin
            d = exp_q.pop_front();
        end
        n = 5 + int'(bits);
        p = int'(cfg_div) + 1;
        for (int i = 0; i < 8; i++) if (i >= n) d[i] = 1'b0;
        ev[0] = 1'b0;
        for (int i = 0; i < n; i++) ev[i+1] = d[i];
        l = n + 1;
        if (par_en) begin
            case (par_sel)
                2'b00:   ev[l] = ~(^d);
                2'b01:   ev[l] = ^d;
                2'b10:   ev[l] = 1'b0;
                default: ev[l] = 1'b1;
            endcase
            l++;
        end
        ev[l] = 1'b1; l++;
        if (stop2) begin ev[l] = 1'b1; l++; end
        for (int b = 0; b < l; b++) begin
            for (int k = 0; k < p; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (tx !== ev[b]) bad++;
                if (done !== (b == l-1 && k == p-1)) dbad++;
                if (b >= 1 && b <= n && k == 0) obs[b-1] = tx;
            end
        end
        chk("frame_data", obs, d);
        chk("frame_line_bad_cycles", bad, 0);
        chk("frame_done_bad_cycles", dbad, 0);
        nfr++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && rst_n && busy && !tx) rx_frame();
        end
    end

    // Called and returns at a negedge.
    task automatic wr(input logic [7:0] d);
        int t;
        logic acc;
        t = 0;
        tx_data = d;
        tx_valid = 1'b1;
        do begin
            #2;
            if (mon_on) begin
                chk("tx_ready", ready, exp_rdy());
                chk("fifo_cnt", cnt, exp_q.size());
            end
            if (full) full_seen = 1'b1;
            acc = ready;
            @(posedge clk);
            if (acc) exp_q.push_back(d);
            @(negedge clk);
            t++;
        end while (!acc && t < 2000);
        tx_valid = 1'b0;
        if (!acc) chk("write_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", t < 5000, 1);
        @(negedge clk);
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("busy_timeout", t < 200, 1);
    endtask

    task automatic clr_bcnt();
        bcnt_clr = 1'b1;
        @(negedge clk);
        bcnt_clr = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_tx"}, tx, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cnt"}, cnt, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ready"}, ready, cfg_en);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        // reset state
        cfg_en = 1'b1;
        #12;
        reset_vals("rst");
        cfg_en = 1'b0;
        #1;
        chk("rst_ready_en0", ready, 0);
        cfg_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;

        // 8N1, 4 cycles/bit, 0xA5: 40-cycle frame
        cfg_div = 16'd3; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0;
        clr_bcnt();
        wr(8'hA5);
        wait_idle();
        chk("a5_frame_cycles", busy_cyc, 40);

        // 7E2, 2 cycles/bit, 0x53: 11 bit periods
        cfg_div = 16'd1; bits = 2'b10; par_en = 1'b1; par_sel = 2'b01; stop2 = 1'b1;
        clr_bcnt();
        wr(8'h53);
        wait_idle();
        chk("53_frame_cycles", busy_cyc, 22);

        // 10 back-to-back writes at div=0: FIFO fills, frames chain with no gap
        cfg_div = '0; bits = 2'b11; par_en = 1'b0; stop2 = 1'b0;
        full_seen = 1'b0;
        clr_bcnt();
        for (int i = 0; i < 10; i++) wr(8'($urandom));
        wait_idle();
        chk("b2b_busy_cycles", busy_cyc, 100);
        chk("b2b_full_seen", full_seen, 1);

        // break asserted mid-frame only takes effect after the stop bit
        cfg_div = 16'd2;
        wr(8'h3C);
        wait_busy();
        repeat (5) @(negedge clk);
        brk = 1'b1;
        wait_idle();
        chk("break_line_low", tx, 0);
        wr(8'hC3);
        repeat (10) @(negedge clk);
        chk("break_holds_busy", busy, 0);
        chk("break_holds_cnt", cnt, 1);
        brk = 1'b0;
        wait_idle();

        // flush with 3 queued: current frame completes, nothing else goes out
        cfg_div = 16'd3;
        n0 = nfr;
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        clr = 1'b1;
        exp_q.delete();
        @(negedge clk);
        clr = 1'b0;
        #2;
        chk("flush_cnt", cnt, 0);
        chk("flush_empty", empty, 1);
        wait_idle();
        repeat (20) @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_frames", nfr - n0, 1);

        // abort mid-DATA
        mon_on = 1'b0;
        wr(8'h0F);
        wr(8'h33);
        repeat (6) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_cnt", cnt, 1);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", cnt, 1);
        chk("abort_ready", ready, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_clr_cnt", cnt, 0);
        cfg_en = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("abort_after_busy", busy, 0);

        // asynchronous reset mid-frame
        wr(8'h81);
        wr(8'h7E);
        repeat (10) @(negedge clk);
        chk("rst_mid_busy_pre", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("rst_mid_after_busy", busy, 0);
        chk("rst_mid_after_cnt", cnt, 0);
        mon_on = 1'b1;

        // random formats, 3x depth bytes each, exercising pointer wrap
        for (int r = 0; r < 6; r++) begin
            cfg_div = DW'($urandom_range(0, 3));
            bits    = 2'($urandom);
            par_en  = 1'($urandom);
            par_sel = 2'($urandom);
            stop2   = 1'($urandom);
            for (int i = 0; i < 3*DEPTH; i++) begin
                wr(8'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
